// File: rtl/seq_shift_right_unit.sv
// seq_shift_right_unit: iterative right shifter for SRL/SRA/SRLV/SRAV, one bit per clock.
// Latency: done is high in the cycle after start edge + shamt + 1 (shamt=0 -> 1 cycle, shamt=31 -> 32 cycles).
// Backpressure: start is only sampled in IDLE; while busy an asserted start is ignored and nothing is latched.
module seq_shift_right_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5     // 2**SHAMT_W must cover WIDTH so every MIPS shift amount is expressible
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               sign_q, sign_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and datapath: load on accepted start, shift one bit per SHIFT cycle, hold otherwise.
  // The fill bit is frozen at load time, so an oversized shamt simply saturates to all-fill.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    sign_d   = sign_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          result_d = operand;
          count_d  = shamt;
          sign_d   = arith & operand[WIDTH-1];
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q != CNT_ZERO) begin
          result_d = {sign_q, result_q[WIDTH-1:1]};
          count_d  = count_q - CNT_ONE;
        end else begin
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are decoded from the next state and registered, giving Moore timing without a decode stage.
    busy_d = (state_d == SHIFT) || (state_d == DONE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset wins over any in-flight operation and discards the partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_shift_right_unit.sv
// Self-checking bench for seq_shift_right_unit: directed cases plus randomized operations against a shift-operator model.
// Outputs are sampled 1 time unit after the rising edge; inputs change on the falling edge.
// Every wait for done is bounded, so a stuck design still reaches the summary line.
module tb_seq_shift_right_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vec_cnt = 0;
  int err_cnt = 0;

  seq_shift_right_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (operand),
    .shamt   (shamt),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: a MIPS SRL/SRA is just the language shift operator on the original operand.
  function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [4:0] sh, input logic ar);
    if (ar) return $signed(op) >>> sh;
    return op >> sh;
  endfunction

  // Issue one start from IDLE, report cycles from the start edge to done, the result at done,
  // busy one cycle after start, and done one cycle after the pulse; leaves the DUT back in IDLE.
  task automatic run_op(input logic [31:0] op, input logic [4:0] sh, input logic ar,
                        output int lat, output logic [31:0] res, output logic busy_e1,
                        output logic done_after);
    @(negedge clk);
    operand = op; shamt = sh; arith = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_e1 = busy;
    lat = -1;
    res = 32'hxxxx_xxxx;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; operand = '0; shamt = '0; arith = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", done); end
    vec_cnt++; if (result !== 32'h0) begin err_cnt++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] res; logic b1, da;
    run_op(32'd8, 5'd2, 1'b0, lat, res, b1, da);
    vec_cnt++; if (b1 !== 1'b1) begin err_cnt++; $display("FAIL basic8_busy got %b want 1", b1); end
    vec_cnt++; if (lat != 3) begin err_cnt++; $display("FAIL basic8_latency got %0d want 3", lat); end
    vec_cnt++; if (res !== 32'd2) begin err_cnt++; $display("FAIL basic8_result got %h want 2", res); end
    vec_cnt++; if (da !== 1'b0) begin err_cnt++; $display("FAIL basic8_done_width got %b want 0", da); end
    run_op(32'd16, 5'd2, 1'b0, lat, res, b1, da);
    vec_cnt++; if (lat != 3) begin err_cnt++; $display("FAIL basic16_latency got %0d want 3", lat); end
    vec_cnt++; if (res !== 32'd4) begin err_cnt++; $display("FAIL basic16_result got %h want 4", res); end
    // result must persist in IDLE and not be cleared after done
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (result !== 32'd4) begin err_cnt++; $display("FAIL idle_hold got %h want 4", result); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_srl_sra();
    int lat; logic [31:0] res; logic b1, da;
    run_op(32'h8000_0000, 5'd4, 1'b0, lat, res, b1, da);
    vec_cnt++; if (lat != 5) begin err_cnt++; $display("FAIL srl_latency got %0d want 5", lat); end
    vec_cnt++; if (res !== 32'h0800_0000) begin err_cnt++; $display("FAIL srl_result got %h want 08000000", res); end
    run_op(32'h8000_0000, 5'd4, 1'b1, lat, res, b1, da);
    vec_cnt++; if (lat != 5) begin err_cnt++; $display("FAIL sra_latency got %0d want 5", lat); end
    vec_cnt++; if (res !== 32'hF800_0000) begin err_cnt++; $display("FAIL sra_result got %h want f8000000", res); end
  endtask

  task automatic test_boundaries();
    int lat; logic [31:0] res; logic b1, da;
    run_op(32'hDEAD_BEEF, 5'd0, 1'b1, lat, res, b1, da);
    vec_cnt++; if (lat != 1) begin err_cnt++; $display("FAIL sh0_latency got %0d want 1", lat); end
    vec_cnt++; if (res !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL sh0_result got %h want deadbeef", res); end
    run_op(32'hFFFF_FFF0, 5'd31, 1'b1, lat, res, b1, da);
    vec_cnt++; if (lat != 32) begin err_cnt++; $display("FAIL sh31a_latency got %0d want 32", lat); end
    vec_cnt++; if (res !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL sh31a_result got %h want ffffffff", res); end
    run_op(32'hFFFF_FFF0, 5'd31, 1'b0, lat, res, b1, da);
    vec_cnt++; if (lat != 32) begin err_cnt++; $display("FAIL sh31l_latency got %0d want 32", lat); end
    vec_cnt++; if (res !== 32'h0000_0001) begin err_cnt++; $display("FAIL sh31l_result got %h want 00000001", res); end
  endtask

  task automatic test_busy_pulse();
    int pulses; int lat; logic [31:0] res;
    pulses = 0; lat = -1; res = 32'hxxxx_xxxx;
    @(negedge clk);
    operand = 32'h100; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin
        operand = 32'hFFFF; shamt = 5'd1; arith = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (lat < 0) begin lat = k; res = result; end
      end
    end
    vec_cnt++; if (pulses != 1) begin err_cnt++; $display("FAIL busy_pulse_count got %0d want 1", pulses); end
    vec_cnt++; if (lat != 9) begin err_cnt++; $display("FAIL busy_pulse_latency got %0d want 9", lat); end
    vec_cnt++; if (res !== 32'h1) begin err_cnt++; $display("FAIL busy_pulse_result got %h want 00000001", res); end
  endtask

  task automatic test_back_to_back();
    int pulses; int t1, t2; logic [31:0] r1, r2;
    pulses = 0; t1 = -1; t2 = -1; r1 = 32'hxxxx_xxxx; r2 = 32'hxxxx_xxxx;
    @(negedge clk);
    operand = 32'hF0F0_0000; shamt = 5'd3; arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          t1 = k; r1 = result;
          operand = 32'h1234_5678; shamt = 5'd5; arith = 1'b0;
        end else if (pulses == 2) begin
          t2 = k; r2 = result;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    vec_cnt++; if (pulses != 2) begin err_cnt++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    vec_cnt++; if (t1 != 4) begin err_cnt++; $display("FAIL b2b_first_latency got %0d want 4", t1); end
    vec_cnt++; if (r1 !== ref_shift(32'hF0F0_0000, 5'd3, 1'b1)) begin err_cnt++; $display("FAIL b2b_first_result got %h want %h", r1, ref_shift(32'hF0F0_0000, 5'd3, 1'b1)); end
    vec_cnt++; if (t2 - t1 != 8) begin err_cnt++; $display("FAIL b2b_gap got %0d want 8", t2 - t1); end
    vec_cnt++; if (r2 !== ref_shift(32'h1234_5678, 5'd5, 1'b0)) begin err_cnt++; $display("FAIL b2b_second_result got %h want %h", r2, ref_shift(32'h1234_5678, 5'd5, 1'b0)); end
  endtask

  task automatic test_reset_mid();
    int pulses; int lat; logic [31:0] res; logic b1, da;
    pulses = 0;
    @(negedge clk);
    operand = $urandom | 32'h8000_0000; shamt = 5'd20; arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy got %b want 0", busy); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rstmid_done got %b want 0", done); end
    vec_cnt++; if (result !== 32'h0) begin err_cnt++; $display("FAIL rstmid_result got %h want 0", result); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    vec_cnt++; if (pulses != 0) begin err_cnt++; $display("FAIL rstmid_stray_done got %0d want 0", pulses); end
    run_op(32'hA5A5_0000, 5'd7, 1'b1, lat, res, b1, da);
    vec_cnt++; if (lat != 8) begin err_cnt++; $display("FAIL rstmid_after_latency got %0d want 8", lat); end
    vec_cnt++; if (res !== ref_shift(32'hA5A5_0000, 5'd7, 1'b1)) begin err_cnt++; $display("FAIL rstmid_after_result got %h want %h", res, ref_shift(32'hA5A5_0000, 5'd7, 1'b1)); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res; logic b1, da;
    logic [31:0] op; logic [4:0] sh; logic ar;
    for (int i = 0; i < 24; i++) begin
      op = $urandom;
      sh = 5'($urandom_range(0, 31));
      ar = 1'($urandom_range(0, 1));
      run_op(op, sh, ar, lat, res, b1, da);
      vec_cnt++; if (lat != int'(sh) + 1) begin err_cnt++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, int'(sh) + 1); end
      vec_cnt++; if (res !== ref_shift(op, sh, ar)) begin err_cnt++; $display("FAIL rand%0d_result op=%h sh=%0d ar=%b got %h want %h", i, op, sh, ar, res, ref_shift(op, sh, ar)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_srl_sra();
    test_boundaries();
    test_busy_pulse();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seq_shift_right_unit.md
Name: seq_shift_right_unit

Overview:
- Iterative multi-cycle right shifter. It is the counterpart of the datapath's combinational shift-left-by-2 unit and implements the MIPS SRL/SRA/SRLV/SRAV operations.
- It shifts a latched operand right by one bit per clock until the shift amount is exhausted, then pulses done.
- It sits beside the ALU and is controlled by a start/busy/done handshake from the control unit.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W >= WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a shift; sampled only when busy=0.
- operand  input  WIDTH  value to shift; latched on an accepted start.
- shamt  input  SHAMT_W  shift amount, 0..2^SHAMT_W-1; latched on an accepted start.
- arith  input  1  0 = logical (zero fill), 1 = arithmetic (sign fill); latched on an accepted start.
- busy  output  1  high while an operation is in progress (states SHIFT and DONE).
- done  output  1  one-cycle pulse when result is final.
- result  output  WIDTH  shift result; held stable from done until the next accepted start.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state=IDLE, result=0, count=0, sign=0, busy=0, done=0.
  - Reset takes priority over every other input, including mid-operation; a partially shifted result is discarded and becomes 0.
- States: IDLE, SHIFT, DONE. The block uses a Moore encoding: busy=1 in SHIFT and DONE; done=1 only in DONE.
- IDLE:
  - If start=1, then on the edge: result<=operand, count<=shamt, sign<=arith & operand[WIDTH-1], and the state goes to SHIFT.
  - Otherwise the block holds all state.
- SHIFT:
  - If count!=0: result<={sign, result[WIDTH-1:1]} and count<=count-1.
  - If count==0: go to DONE; result is unchanged.
- DONE: go to IDLE on the next edge; result is held.
- Latency:
  - With the start edge called E0, done is high during the cycle after edge E0+N+1, where N = latched shamt.
  - For shamt=0, done rises 1 cycle after the start edge; for shamt=31, 32 cycles after.
  - Back-to-back: a new start is accepted on the first edge seen in IDLE, i.e. the edge after the DONE cycle.
- Handshake:
  - start is ignored while busy=1; an ignored start does not alter operand, count or the mode.
  - start may be held high continuously; each accepted start produces exactly one done pulse.
  - Inputs operand/shamt/arith may change freely after acceptance.
- Arithmetic:
  - The sign bit is captured once at load; arithmetic fill replicates the original MSB.
  - Logical fill is 0.
  - shamt >= WIDTH (possible only if SHAMT_W is oversized) yields all-sign-fill. No wrap-around and no rotate.
- result keeps its previous value in IDLE and is not cleared by done.

Test Plan:
- Reset, then start with operand=8, shamt=2, arith=0 -> busy rises the cycle after start; done pulses 3 cycles after the start edge with result=2. Repeat with operand=16 -> result=4.
- SRL vs SRA on operand=0x80000000, shamt=4: arith=0 -> 0x08000000; arith=1 -> 0xF8000000; done 5 cycles after start in both cases.
- Boundaries:
  - shamt=0, operand=0xDEADBEEF -> result=0xDEADBEEF, done 1 cycle after start.
  - shamt=31, operand=0xFFFFFFF0: arith=1 -> 0xFFFFFFFF; arith=0 -> 0x00000001; done 32 cycles after start.
- Pulse during busy: start with operand=0x100, shamt=8; pulse start again with operand=0xFFFF, shamt=1 at cycle 3 -> second request ignored, result=0x00000001, exactly one done pulse. A start held high through DONE is accepted on the following IDLE edge.
- Reset mid-operation: start with shamt=20, assert rst at cycle 6 -> next cycle busy=0, done=0, result=0; no done pulse follows; a subsequent start completes normally.
